aes_key_schedule: RTL
=====================

Name: aes_key_schedule

Overview:
- Upstream stage of the AES encipher round engine. Expands a 128- or 256-bit cipher key into the full set of round keys: 11 keys for AES-128, 15 for AES-256.
- Stores the round keys and serves them combinationally, indexed by the round number that the encipher engine drives.
- Shares the single 4-byte S-box with the encipher engine. The top level routes the S-box to this block while ready=0.
- Produces one round key per clock.

Parameters:
- None. All widths are fixed by FIPS-197: 15 key slots of 128 bits each.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- init  in  1  start expansion; sampled only when ready=1
- keylen  in  1  0 = AES-128, 1 = AES-256; latched at init
- key  in  256  cipher key. AES-128 uses key[255:128] only; key[127:0] is ignored.
- round  in  4  round-key index from the encipher engine
- round_key  out  128  round key stored in slot [round]
- sboxw  out  32  word to substitute (to the shared S-box)
- new_sboxw  in  32  substituted word (from the S-box, same cycle)
- ready  out  1  1 = idle, and the key set is valid once an expansion has completed

Behaviour:

Reset values:
- ready=1, sboxw=0.
- All 15 slots = 0, so round_key=0.
- State = IDLE, rcon = 8'h01, kctr = 0.

States: IDLE and GEN.

IDLE:
- init=1 latches key and keylen, sets kctr=0 and rcon=8'h01, and clears ready on the next edge.
- The state moves to GEN.
- init while in GEN is ignored.

GEN writes one slot per cycle, at slot[kctr]:
- kctr=0: slot0 = key[255:128].
- kctr=1 with AES-256: slot1 = key[127:0].
- Otherwise, with P = slot[kctr-1], Q = slot[kctr-2] for AES-256 or P for AES-128, and t = P[31:0]:
  - If AES-128, or AES-256 with even kctr: sboxw = RotWord(t) = {t[23:0],t[31:24]}; g = new_sboxw ^ {rcon,24'h0}; rcon <= xtime(rcon) after use, where xtime(x) = {x[6:0],0} ^ (8'h1b & {8{x[7]}}).
  - If AES-256 with odd kctr (>=3): sboxw = t, g = new_sboxw, rcon unchanged.
  - w0 = Q[127:96]^g, w1 = Q[95:64]^w0, w2 = Q[63:32]^w1, w3 = Q[31:0]^w2; slot[kctr] = {w0,w1,w2,w3}.
- kctr increments each cycle. When kctr == N (N = 10 for AES-128, 14 for AES-256), the final slot is written, ready <= 1, and the state returns to IDLE.

Latency:
- init sampled at edge 0 gives ready=0 for exactly N+1 cycles, then ready=1.
- AES-128: 11 cycles. AES-256: 15 cycles.

Outputs:
- sboxw = 0 in IDLE and on the cycles that need no substitution (kctr=0, and kctr=1 for AES-256).
- round_key = slot[round], combinational. round > 14 returns 0.
- Reads while ready=0 return the current slot contents, which may be stale; consumers must not rely on them.
- After an AES-128 expansion, slots 11-14 keep their previous values.

Boundary conditions:
- rcon sequence used: 01,02,04,08,10,20,40,80,1b,36 for AES-128; 01..40 (7 values) for AES-256.
- Reset mid-GEN: immediate return to the reset state, all slots cleared, ready=1.
- key/keylen changing during GEN: no effect, because both were latched at init.
- init held high continuously: a new expansion starts on each IDLE cycle in which it is sampled. Back-to-back expansions are therefore separated by exactly one IDLE cycle.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- When defined:
  - Adds input port zeroize (1 bit).
  - zeroize=1 in any state clears all 15 slots and rcon on the next edge, aborts GEN, returns to IDLE with ready=1, and drives sboxw=0.
  - zeroize has priority over a simultaneous init; that init is dropped.
- When undefined: no port. Slots are only overwritten by a new expansion or by reset.

Test Plan:
- AES-128, key[255:128] = 2b7e151628aed2a6abf7158809cf4f3c -> ready low 11 cycles; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-256, key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> ready low 15 cycles; round 2 = 9ba354118e6925afa51a8b5f2067fcde; round 14 = fe4890d1e6188d0b046df344706c631e.
- init pulsed while busy (cycle 5 of GEN), with key changed at the same time -> ignored; round 10 still matches the first key's vector.
- reset_n asserted at GEN cycle 6 -> ready=1 and round_key=0 for every round index; a new init then completes normally.
- round = 15 after any expansion -> round_key = 0. After AES-256 then AES-128 expansions, round 12 still returns the AES-256 value.
- With AES_KEY_ZEROIZE_EN: zeroize at GEN cycle 3 together with init -> next cycle ready=1 and all rounds return 0; no restart occurs.

Source files
------------

// File: rtl/aes_key_schedule_if.sv
// Key-schedule bus between the AES encipher engine (master) and the
// round-key expansion block (slave). The master side also carries the
// shared S-box result back to the key schedule.
`timescale 1ns/1ps
interface aes_key_schedule_if;
    logic         init;
    logic         keylen;
    logic [255:0] key;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic         ready;

    modport master (
        output init, keylen, key, round, new_sboxw,
        input  round_key, sboxw, ready
    );

    modport slave (
        input  init, keylen, key, round, new_sboxw,
        output round_key, sboxw, ready
    );
endinterface

// File: rtl/aes_key_schedule.sv
// AES key schedule: expands a 128- or 256-bit cipher key into 11 or 15
// round keys, one slot per clock, using the S-box shared with the
// encipher engine. Round keys are served combinationally by index.
// Optional build macro AES_KEY_ZEROIZE_EN adds a zeroize input that wipes
// the stored key material and aborts any expansion in progress.
`timescale 1ns/1ps
module aes_key_schedule (
    input  logic clk,
    input  logic reset_n,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes_key_schedule_if.slave ks
);

    typedef enum logic {IDLE, GEN} state_t;

    state_t         state_q;
    logic           ready_q;
    logic           keylen_q;
    logic [3:0]     kctr_q;
    logic [7:0]     rcon_q;
    logic [255:0]   key_q;
    logic [127:0]   slot_q [15];

    logic [127:0]   slot_d;
    logic [127:0]   prev_w;
    logic [127:0]   back_w;
    logic [31:0]    t_w;
    logic [31:0]    g_w;
    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    sboxw_d;
    logic           rot_en;
    logic           sub_en;
    logic           last_slot;
    logic           zero_req;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // GF(2^8) multiply by x, used to advance the round constant
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    // Next slot value: either a raw key half or the four chained key words
    always_comb begin
        prev_w = '0;
        if (kctr_q != 4'd0) begin
            prev_w = slot_q[kctr_q - 4'd1];
        end
        // AES-256 chains against the slot two back; AES-128 against the previous one
        back_w = prev_w;
        if (keylen_q && (kctr_q >= 4'd2)) begin
            back_w = slot_q[kctr_q - 4'd2];
        end
        t_w    = prev_w[31:0];
        rot_en = !keylen_q || !kctr_q[0];
        sub_en = (state_q == GEN) && (kctr_q != 4'd0) && !(keylen_q && (kctr_q == 4'd1));

        sboxw_d = '0;
        if (sub_en) begin
            sboxw_d = rot_en ? {t_w[23:0], t_w[31:24]} : t_w;
        end

        g_w = rot_en ? (ks.new_sboxw ^ {rcon_q, 24'h0}) : ks.new_sboxw;
        w0  = back_w[127:96] ^ g_w;
        w1  = back_w[95:64]  ^ w0;
        w2  = back_w[63:32]  ^ w1;
        w3  = back_w[31:0]   ^ w2;

        if (kctr_q == 4'd0) begin
            slot_d = key_q[255:128];
        end else if (keylen_q && (kctr_q == 4'd1)) begin
            slot_d = key_q[127:0];
        end else begin
            slot_d = {w0, w1, w2, w3};
        end

        last_slot = (kctr_q == (keylen_q ? 4'd14 : 4'd10));
    end

    // Control FSM and round-key storage; zeroize (when built in) overrides init
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            keylen_q <= 1'b0;
            kctr_q   <= 4'd0;
            rcon_q   <= 8'h01;
            key_q    <= '0;
            for (int i = 0; i < 15; i++) begin
                slot_q[i] <= '0;
            end
        end else if (zero_req) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            kctr_q  <= 4'd0;
            rcon_q  <= 8'h00;
            // the latched cipher key is key material too, so it goes with the slots
            key_q   <= '0;
            for (int i = 0; i < 15; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ks.init) begin
                        key_q    <= ks.key;
                        keylen_q <= ks.keylen;
                        kctr_q   <= 4'd0;
                        rcon_q   <= 8'h01;
                        ready_q  <= 1'b0;
                        state_q  <= GEN;
                    end
                end
                GEN: begin
                    slot_q[kctr_q] <= slot_d;
                    if (sub_en && rot_en) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    kctr_q <= kctr_q + 4'd1;
                    if (last_slot) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ks.sboxw     = sboxw_d;
    assign ks.ready     = ready_q;
    assign ks.round_key = (ks.round == 4'd15) ? '0 : slot_q[ks.round];

endmodule
